// File: rtl/decoder_2to4_stream_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg : shared state encoding, decoded-word type and decode function
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package decoder_pkg;

    localparam int c_MAX_OUT    = 16;
    localparam int c_CODE_MAX_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } dec_state_e;

    // Sized for the widest legal build; narrower tops use the low bits only.
    typedef struct packed {
        logic                 err;
        logic [c_MAX_OUT-1:0] onehot;
    } dec_word_t;

    function automatic dec_word_t decode_f(
        input logic [c_CODE_MAX_W-1:0] code,
        input logic                    en,
        input int unsigned             num_out
    );
        dec_word_t w;
        w = '0;
        if (en) begin
            if (32'(code) < num_out) begin
                w.onehot[code] = 1'b1;
            end else begin
                w.err = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_2to4_stream_if.sv
// ----------------------------------------------------------------------------
// decoder_2to4_stream_if : code-in / one-hot-out stream bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface decoder_2to4_stream_if #(
    parameter int NUM_OUT = 4,
    parameter int CNT_W   = 16
);
    localparam int CODE_W = $clog2(NUM_OUT);

    logic [CODE_W-1:0]  in_code;
    logic               in_en;
    logic               in_valid;
    logic               in_ready;
    logic [NUM_OUT-1:0] dec_out;
    logic               dec_err;
    logic               out_valid;
    logic               out_ready;
    logic [CNT_W-1:0]   xfer_cnt;

    modport slave (
        input  in_code, in_en, in_valid, out_ready,
        output in_ready, dec_out, dec_err, out_valid, xfer_cnt
    );

    modport master (
        output in_code, in_en, in_valid, out_ready,
        input  in_ready, dec_out, dec_err, out_valid, xfer_cnt
    );

endinterface

`default_nettype wire

// File: rtl/decoder_2to4_stream_skid_reg.sv
// ----------------------------------------------------------------------------
// decoder_skid_reg : output register plus 1-entry skid buffer over dec_word_t
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decoder_skid_reg
    import decoder_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      i_in_valid,
    output logic           o_in_ready,
    input  wire dec_word_t i_in_data,
    output logic           o_out_valid,
    input  wire logic      i_out_ready,
    output dec_word_t      o_out_data
);

    dec_state_e r_state_q, w_state_d;
    dec_word_t  r_out_q, w_out_d;
    dec_word_t  r_skid_q, w_skid_d;
    logic       r_in_ready_q, w_in_ready_d;
    logic       r_out_valid_q, w_out_valid_d;
    logic       w_acc;
    logic       w_drn;

    always_comb begin
        w_state_d = r_state_q;
        w_out_d   = r_out_q;
        w_skid_d  = r_skid_q;
        w_acc     = i_in_valid && r_in_ready_q;
        w_drn     = i_out_ready && r_out_valid_q;

        case (r_state_q)
            EMPTY: begin
                if (w_acc) begin
                    w_out_d   = i_in_data;
                    w_state_d = FULL;
                end
            end
            FULL: begin
                if (w_acc && w_drn) begin
                    w_out_d = i_in_data;
                end else if (w_acc) begin
                    w_skid_d  = i_in_data;
                    w_state_d = SKID;
                end else if (w_drn) begin
                    w_state_d = EMPTY;
                end
            end
            SKID: begin
                if (w_drn) begin
                    w_out_d   = r_skid_q;
                    w_state_d = FULL;
                end
            end
            default: w_state_d = EMPTY;
        endcase

        // Handshake flags are flopped copies of the next state.
        w_in_ready_d  = (w_state_d != SKID);
        w_out_valid_d = (w_state_d != EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= EMPTY;
            r_out_q       <= '0;
            r_skid_q      <= '0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_out_q       <= w_out_d;
            r_skid_q      <= w_skid_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign o_in_ready  = r_in_ready_q;
    assign o_out_valid = r_out_valid_q;
    assign o_out_data  = r_out_q;

endmodule

`default_nettype wire

// File: rtl/decoder_2to4_stream.sv
// ----------------------------------------------------------------------------
// decoder_2to4_stream : registered valid/ready binary-to-one-hot decoder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decoder_2to4_stream
    import decoder_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    decoder_2to4_stream_if.slave   bus
);

    dec_word_t               w_in_word;
    dec_word_t               w_out_word;
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_acc;
    logic [c_CODE_MAX_W-1:0] w_code_ext;
    logic [CNT_W-1:0]        r_xfer_cnt_q, w_xfer_cnt_d;
    logic                    w_unused_hi;

    assign w_code_ext = c_CODE_MAX_W'(bus.in_code);
    assign w_in_word  = decode_f(w_code_ext, bus.in_en, 32'(NUM_OUT));

    decoder_skid_reg u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (bus.in_valid),
        .o_in_ready  (w_in_ready),
        .i_in_data   (w_in_word),
        .o_out_valid (w_out_valid),
        .i_out_ready (bus.out_ready),
        .o_out_data  (w_out_word)
    );

    assign w_acc = bus.in_valid && w_in_ready;

    always_comb begin
        w_xfer_cnt_d = r_xfer_cnt_q;
        if (w_acc) begin
            w_xfer_cnt_d = r_xfer_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt_q <= '0;
        end else begin
            r_xfer_cnt_q <= w_xfer_cnt_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.dec_out   = w_out_word.onehot[NUM_OUT-1:0];
    assign bus.dec_err   = w_out_word.err;
    assign bus.xfer_cnt  = r_xfer_cnt_q;
    // Bits above NUM_OUT are always zero from decode_f.
    assign w_unused_hi   = ^w_out_word.onehot;

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid |-> $onehot0(bus.dec_out));
    a_err_zero: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && bus.dec_err) |-> (bus.dec_out == '0));

endmodule

`default_nettype wire

// File: tb/tb_decoder_2to4_stream.sv
// ----------------------------------------------------------------------------
// tb_decoder_2to4_stream : random and directed checks of 4-way and 3-way builds
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decoder_2to4_stream;

    logic clk;
    logic rst;
    logic       s_valid;
    logic [1:0] s_code;
    logic       s_en;
    logic       s_ordy;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] oh;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cnta = 0;
    int   cntb = 0;

    decoder_2to4_stream_if #(.NUM_OUT(4), .CNT_W(16)) ifa ();
    decoder_2to4_stream_if #(.NUM_OUT(3), .CNT_W(4))  ifb ();

    assign ifa.in_valid  = s_valid;
    assign ifa.in_code   = s_code;
    assign ifa.in_en     = s_en;
    assign ifa.out_ready = s_ordy;
    assign ifb.in_valid  = s_valid;
    assign ifb.in_code   = s_code;
    assign ifb.in_en     = s_en;
    assign ifb.out_ready = s_ordy;

    decoder_2to4_stream #(.NUM_OUT(4), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    decoder_2to4_stream #(.NUM_OUT(3), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t ref_word(input int code, input bit en, input int n);
        exp_t r;
        r.oh  = '0;
        r.err = 1'b0;
        if (en) begin
            if (code < n) r.oh = 16'(1 << code);
            else          r.err = 1'b1;
        end
        return r;
    endfunction

    // The block holds at most two words: one presented, one parked.
    task automatic check_all();
        check_eq("a_valid", 32'(ifa.out_valid), 32'(qa.size() > 0));
        check_eq("a_ready", 32'(ifa.in_ready),  32'(qa.size() < 2));
        check_eq("a_cnt",   32'(ifa.xfer_cnt),  cnta & 32'hFFFF);
        if (qa.size() > 0) begin
            check_eq("a_out",  32'(ifa.dec_out), 32'(qa[0].oh));
            check_eq("a_err",  32'(ifa.dec_err), 32'(qa[0].err));
            check_eq("a_1hot", 32'($onehot0(ifa.dec_out)), 32'd1);
        end
        check_eq("b_valid", 32'(ifb.out_valid), 32'(qb.size() > 0));
        check_eq("b_ready", 32'(ifb.in_ready),  32'(qb.size() < 2));
        check_eq("b_cnt",   32'(ifb.xfer_cnt),  cntb & 32'hF);
        if (qb.size() > 0) begin
            check_eq("b_out",  32'(ifb.dec_out), 32'(qb[0].oh));
            check_eq("b_err",  32'(ifb.dec_err), 32'(qb[0].err));
            check_eq("b_1hot", 32'($onehot0(ifb.dec_out)), 32'd1);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input int c, input bit e, input bit r);
        bit acc_a, drn_a, acc_b, drn_b;
        check_all();
        s_valid = v;
        s_code  = 2'(c);
        s_en    = e;
        s_ordy  = r;
        #1;
        acc_a = v && ifa.in_ready;
        drn_a = r && ifa.out_valid;
        acc_b = v && ifb.in_ready;
        drn_b = r && ifb.out_valid;
        @(posedge clk);
        if (drn_a && qa.size() > 0) void'(qa.pop_front());
        if (drn_b && qb.size() > 0) void'(qb.pop_front());
        if (acc_a) begin qa.push_back(ref_word(c, e, 4)); cnta++; end
        if (acc_b) begin qb.push_back(ref_word(c, e, 3)); cntb++; end
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_code  = '0;
        s_en    = 1'b0;
        s_ordy  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(ifa.out_valid), 32'd0);
        check_eq("rst_ready", 32'(ifa.in_ready),  32'd1);
        check_eq("rst_out",   32'(ifa.dec_out),   32'd0);
        check_eq("rst_err",   32'(ifa.dec_err),   32'd0);
        check_eq("rst_cnt",   32'(ifa.xfer_cnt),  32'd0);
        rst = 1'b0;

        // Back-to-back codes with a free-flowing sink
        for (int i = 0; i < 4; i++) step(1, i, 1, 1);
        step(0, 0, 0, 1);
        check_eq("t1_cnt", 32'(ifa.xfer_cnt), 32'd4);

        // Disabled decode yields an all-zero word
        step(1, 2, 0, 1);
        check_eq("t2_out", 32'(ifa.dec_out), 32'd0);
        check_eq("t2_vld", 32'(ifa.out_valid), 32'd1);
        step(0, 0, 0, 1);

        // Backpressure: fill output register and skid, then drain
        step(1, 1, 1, 0);
        step(1, 3, 1, 0);
        check_eq("t3_ready", 32'(ifa.in_ready), 32'd0);
        step(0, 0, 0, 0);
        check_eq("t3_hold", 32'(ifa.dec_out), 32'h2);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Out-of-range code on the 3-output build
        step(1, 3, 1, 1);
        check_eq("t4_err", 32'(ifb.dec_err), 32'd1);
        step(1, 2, 1, 1);
        check_eq("t4_out", 32'(ifb.dec_out), 32'h4);
        step(0, 0, 0, 1);

        // Asynchronous reset while parked in SKID
        step(1, 1, 1, 0);
        step(1, 2, 1, 0);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("t5_valid", 32'(ifa.out_valid), 32'd0);
        check_eq("t5_out",   32'(ifa.dec_out),   32'd0);
        check_eq("t5_cnt",   32'(ifa.xfer_cnt),  32'd0);
        check_eq("t5_ready", 32'(ifa.in_ready),  32'd1);
        check_eq("t5_bcnt",  32'(ifb.xfer_cnt),  32'd0);
        qa.delete();
        qb.delete();
        cnta = 0;
        cntb = 0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Narrow counter wraps after 16 transfers
        for (int i = 0; i < 17; i++) step(1, i % 4, 1, 1);
        step(0, 0, 0, 1);
        check_eq("t6_wrap", 32'(ifb.xfer_cnt), 32'd1);
        check_eq("t6_acnt", 32'(ifa.xfer_cnt), 32'd17);

        // Random handshake stress
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check_all();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder_2to4_stream.md
Name: decoder_2to4_stream

Overview:
Registered, flow-controlled binary-to-one-hot decoder, the inverse of the team's one-hot-to-binary encoder. It accepts a binary code per valid/ready transfer and emits the matching one-hot vector on a registered output stream. A 1-entry skid buffer gives full throughput with a registered in_ready. It sits between a control FSM producing select indices and downstream one-hot select/enable consumers.

Parameters:
NUM_OUT, 4, number of one-hot output lines; legal range 2..16.
CNT_W, 16, width of the accepted-transfer counter.
CODE_W (localparam), $clog2(NUM_OUT), width of the input code.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_code  input  CODE_W  binary index to decode.
in_en  input  1  decode enable; 0 requests an all-zero output word.
in_valid  input  1  upstream word valid.
in_ready  output  1  block can accept a word; registered.
dec_out  output  NUM_OUT  one-hot decoded word; bit in_code set.
dec_err  output  1  this output word had in_code >= NUM_OUT.
out_valid  output  1  dec_out/dec_err valid.
out_ready  input  1  downstream accepts the word.
xfer_cnt  output  CNT_W  number of accepted input transfers.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All state is cleared on rst assertion without waiting for a clock edge.
- Reset values: dec_out=0, dec_err=0, out_valid=0, in_ready=1, xfer_cnt=0, skid buffer empty.
- Decode function, which is pure and applied at accept time:
  - in_en=0 -> word 0, err 0.
  - in_en=1 and in_code<NUM_OUT -> word = 1<<in_code, err 0.
  - in_en=1 and in_code>=NUM_OUT -> word 0, err 1. This case is only reachable when NUM_OUT is not a power of 2.
- Transfers: an input transfer occurs when in_valid&&in_ready. An output transfer occurs when out_valid&&out_ready.
- Latency: a word accepted in cycle N appears on dec_out with out_valid=1 in cycle N+1, provided the output register was empty or draining in cycle N.
- States (2-bit FSM, encoded in a package enum):
  - EMPTY: out_valid=0, in_ready=1. On accept -> FULL, with the output register loaded.
  - FULL: out_valid=1, in_ready=1.
    - Accept with drain: the output register reloads; stay in FULL.
    - Accept without drain: the word goes to the skid buffer; -> SKID.
    - Drain without accept: -> EMPTY.
    - Neither: hold.
  - SKID: out_valid=1, in_ready=0.
    - On drain: the skid word moves to the output register; -> FULL.
    - Otherwise: hold.
- Outputs are stable while out_valid=1 and out_ready=0. dec_out, dec_err and out_valid must not change in that case.
- Upstream rule: in_code and in_en are sampled only on a transfer. in_valid may drop without a transfer and the block must not care.
- xfer_cnt increments on every input transfer and wraps modulo 2**CNT_W (0xFFFF -> 0x0000 at the default width). It has no saturation.
- dec_out is at most one-hot in every valid cycle; $onehot0(dec_out) is an assertion.
- dec_err=1 implies dec_out==0.
- Reset mid-operation discards any words in the output register and skid buffer. No partial output is emitted after rst deasserts. in_ready is 1 on the first cycle after deassertion.
- Simultaneous accept and drain in SKID is impossible because in_ready=0.

Decomposition:
- Package decoder_pkg holds:
  - enum dec_state_e {EMPTY, FULL, SKID}.
  - Typedef struct dec_word_t {logic err; logic [NUM_OUT-1:0] onehot;}, with NUM_OUT passed via a parameterized function or default 4.
  - Function decode_f(code, en) returning dec_word_t.
- Sub-module decoder_skid_reg holds the generic 1-entry skid buffer and output register over dec_word_t. The top level wraps it with decode_f on the input side and adds xfer_cnt.

Test Plan:
1. Reset, then codes 0,1,2,3 with in_en=1 back-to-back and out_ready=1 -> dec_out 0001,0010,0100,1000 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1; xfer_cnt=4.
2. in_en=0 with in_code=2 -> dec_out=0000, dec_err=0, out_valid=1 for one cycle.
3. Hold out_ready=0 and send codes 1 then 3 -> out_valid=1 with dec_out=0010 held stable; in_ready drops to 0 after the second accept. Raise out_ready -> 0010 then 1000 are delivered, and in_ready returns to 1 one cycle after the first drain.
4. NUM_OUT=3 build: send in_code=3, in_en=1 -> dec_out=000, dec_err=1. Then in_code=2 -> dec_out=100, dec_err=0.
5. Assert rst asynchronously mid-cycle while in SKID -> out_valid, dec_out and xfer_cnt read 0 immediately, in_ready=1; no stale word appears after release.
6. CNT_W=4 build: 17 accepted transfers -> xfer_cnt reads 0x1 (wraps from 0xF to 0x0); random valid/ready stress holds $onehot0 and in-order delivery with no loss or duplication.
